// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle control FSM (IF/ID/EX/MEM/WB) with memory handshake.
// Optional instruction counter output enabled by macro CONTROLE_INSTR_CNT_EN.
module controle_multiciclo (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        b_mx,
  output logic        j_mx,
  output logic        r_mx,
  output logic        se_mx,
  output logic        d_mx,
  output logic [3:0]  ula,
  output logic        we,
  output logic        re
`ifdef CONTROLE_INSTR_CNT_EN
  ,
  output logic [15:0] instr_cnt
`endif
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;

  logic is_branch, is_jump, is_load, is_store, is_mem, is_alu;
  logic [3:0] alu_ula;

  assign is_branch = (op_q == 4'b0000);
  assign is_jump   = (op_q == 4'b0001);
  assign is_load   = (op_q == 4'b0010);
  assign is_store  = (op_q == 4'b0011);
  assign is_mem    = is_load | is_store;
  assign is_alu    = (op_q[3:2] != 2'b00);

  // 1000-1111 map to opcode-1000, i.e. the low three bits
  always_comb begin
    case (op_q)
      4'b0100: alu_ula = 4'b0100;
      4'b0101: alu_ula = 4'b0101;
      4'b0110: alu_ula = 4'b1000;
      4'b0111: alu_ula = 4'b1001;
      default: alu_ula = {1'b0, op_q[2:0]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      op_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IF: begin
        if (mem_ready) begin
          op_d    = opcode;
          state_d = S_ID;
        end
      end
      S_ID: state_d = S_EX;
      S_EX: begin
        if (is_branch || is_jump) state_d = S_IF;
        else if (is_mem)          state_d = S_MEM;
        else                      state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) state_d = is_load ? S_WB : S_IF;
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // rst gates the outputs directly so they drop without waiting for a clock edge
  always_comb begin
    mem_req = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    b_mx    = 1'b0;
    j_mx    = 1'b0;
    r_mx    = 1'b0;
    se_mx   = 1'b0;
    d_mx    = 1'b0;
    ula     = 4'b0000;
    we      = 1'b0;
    re      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        S_EX: begin
          if (is_branch) begin
            b_mx  = 1'b1;
            pc_we = zero;
          end else if (is_jump) begin
            j_mx  = 1'b1;
            pc_we = 1'b1;
          end else if (is_alu) begin
            ula = alu_ula;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          we      = is_store;
        end
        S_WB: begin
          re = 1'b1;
          if (is_alu) begin
            d_mx  = 1'b1;
            ula   = alu_ula;
            r_mx  = (op_q == 4'b0100) || (op_q == 4'b0101);
            se_mx = (op_q == 4'b0100) || (op_q == 4'b0101);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONTROLE_INSTR_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_IF && state_d == S_IF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 16'd0;
    else     cnt_q <= cnt_d;
  end

  assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb/tb_controle_multiciclo.sv - directed-vector self-checking bench for controle_multiciclo.
// Output vector order: {mem_req, ir_we, pc_we, b, j, r, se, d, ula, we, re}.
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = 4'b0000;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, ir_we, pc_we, b_mx, j_mx, r_mx, se_mx, d_mx, we, re;
  logic [3:0]  ula;
`ifdef CONTROLE_INSTR_CNT_EN
  logic [15:0] instr_cnt;
  int          exp_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [13:0] IF_W = 14'b100_00000_0000_00;
  localparam logic [13:0] IF_G = 14'b111_00000_0000_00;
  localparam logic [13:0] IDLE = 14'b000_00000_0000_00;

  logic [13:0] outs;
  assign outs = {mem_req, ir_we, pc_we, b_mx, j_mx, r_mx, se_mx, d_mx, ula, we, re};

  always #5 clk = ~clk;

  controle_multiciclo dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .b_mx      (b_mx),
    .j_mx      (j_mx),
    .r_mx      (r_mx),
    .se_mx     (se_mx),
    .d_mx      (d_mx),
    .ula       (ula),
    .we        (we),
    .re        (re)
`ifdef CONTROLE_INSTR_CNT_EN
    ,
    .instr_cnt (instr_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic mr, input logic [3:0] op, input logic z,
                      input string tag, input logic [13:0] exp);
    @(negedge clk);
    mem_ready = mr;
    opcode    = op;
    zero      = z;
    #1;
    check(tag, {18'd0, outs}, {18'd0, exp});
  endtask

  task automatic fetch(input logic [3:0] op, input int waits);
    for (int i = 0; i < waits; i++) step(1'b0, op, 1'b0, "if_wait", IF_W);
    step(1'b1, op, 1'b0, "if_go", IF_G);
  endtask

  task automatic run_alu(input logic [3:0] op, input int waits, input logic [3:0] exp_ula,
                         input logic rse);
    fetch(op, waits);
    step(1'b1, ~op, 1'b0, "alu_id", IDLE);
    step(1'b1, ~op, 1'b0, "alu_ex", {3'b000, 5'b00000, exp_ula, 2'b00});
    step(1'b0, ~op, 1'b0, "alu_wb", {3'b000, 2'b00, rse, rse, 1'b1, exp_ula, 2'b01});
`ifdef CONTROLE_INSTR_CNT_EN
    exp_cnt++;
`endif
  endtask

  task automatic run_branch(input logic z);
    fetch(4'b0000, 1);
    step(1'b0, 4'b1111, z, "br_id", IDLE);
    step(1'b0, 4'b1111, z, "br_ex", {2'b00, z, 5'b10000, 4'b0000, 2'b00});
`ifdef CONTROLE_INSTR_CNT_EN
    exp_cnt++;
`endif
  endtask

  task automatic run_jump();
    fetch(4'b0001, 0);
    step(1'b0, 4'b1010, 1'b0, "jmp_id", IDLE);
    step(1'b0, 4'b1010, 1'b0, "jmp_ex", 14'b001_01000_0000_00);
`ifdef CONTROLE_INSTR_CNT_EN
    exp_cnt++;
`endif
  endtask

  initial begin
    #1;
    check("rst_outs_0", {18'd0, outs}, 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_outs_clk", {18'd0, outs}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("first_mem_req", {18'd0, outs}, {18'd0, IF_W});

    // ALU 0100 with three fetch wait cycles
    run_alu(4'b0100, 3, 4'b0100, 1'b1);
    step(1'b0, 4'b0000, 1'b0, "alu_back_if", IF_W);
    run_alu(4'b0101, 0, 4'b0101, 1'b1);

    run_branch(1'b1);
    run_branch(1'b0);
    run_jump();

    // store: MEM holds we for two cycles until mem_ready
    fetch(4'b0011, 0);
    step(1'b0, 4'b0010, 1'b0, "st_id", IDLE);
    step(1'b1, 4'b0010, 1'b0, "st_ex", IDLE);
    step(1'b0, 4'b0010, 1'b0, "st_mem0", 14'b100_00000_0000_10);
    step(1'b1, 4'b0010, 1'b0, "st_mem1", 14'b100_00000_0000_10);
    step(1'b0, 4'b0010, 1'b0, "st_back_if", IF_W);
`ifdef CONTROLE_INSTR_CNT_EN
    exp_cnt++;
`endif

    // load: MEM then WB with d_mx=r_mx=0
    fetch(4'b0010, 0);
    step(1'b0, 4'b0011, 1'b0, "ld_id", IDLE);
    step(1'b0, 4'b0011, 1'b0, "ld_ex", IDLE);
    step(1'b1, 4'b0011, 1'b0, "ld_mem", 14'b100_00000_0000_00);
    step(1'b0, 4'b0011, 1'b0, "ld_wb", 14'b000_00000_0000_01);
`ifdef CONTROLE_INSTR_CNT_EN
    exp_cnt++;
`endif

    // ALU ula sweep 0110..1111
    for (int k = 6; k < 16; k++) begin
      logic [3:0] op, eu;
      op = k[3:0];
      eu = (k == 6) ? 4'b1000 : (k == 7) ? 4'b1001 : 4'(k - 8);
      run_alu(op, 0, eu, 1'b0);
    end

`ifdef CONTROLE_INSTR_CNT_EN
    step(1'b0, 4'b0000, 1'b0, "if_before_cnt", IF_W);
    check("instr_cnt", {16'd0, instr_cnt}, exp_cnt);
`endif

    // asynchronous reset in the middle of a store's MEM phase
    fetch(4'b0011, 0);
    step(1'b0, 4'b0000, 1'b0, "st2_id", IDLE);
    step(1'b0, 4'b0000, 1'b0, "st2_ex", IDLE);
    step(1'b0, 4'b0000, 1'b0, "st2_mem", 14'b100_00000_0000_10);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs", {18'd0, outs}, 32'd0);
    @(negedge clk);
    #1;
    check("rst_hold_outs", {18'd0, outs}, 32'd0);
`ifdef CONTROLE_INSTR_CNT_EN
    check("rst_instr_cnt", {16'd0, instr_cnt}, 32'd0);
    exp_cnt = 0;
`endif
    rst = 1'b0;
    #1;
    check("after_rst_if", {18'd0, outs}, {18'd0, IF_W});
    run_jump();
    step(1'b0, 4'b0000, 1'b0, "final_if", IF_W);
`ifdef CONTROLE_INSTR_CNT_EN
    check("instr_cnt_end", {16'd0, instr_cnt}, exp_cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
